wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface: the write-back stage merged with the architectural register file.
- Takes the registered MEM/WB outputs and selects write data (load data vs ALU result) from MemtoReg.
- Commits the selected data to the 32-entry GPR array and serves the two ID-stage read ports with same-cycle write-first bypass.
- Exposes the WB result to the forwarding unit, plus a committed-write counter and a debug read port for the bench.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width; array depth is 2**ADDR_W.
- CNT_W, 32, width of the committed-write counter.
- BYPASS, 1, 1 = write-first bypass on read ports; 0 = read returns pre-write array contents.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- wb_RegWrite_i  in  1  write enable from MEM/WB.
- wb_MemtoReg_i  in  1  0 = ALU result, 1 = load data.
- wb_read_data_i  in  DATA_W  load data from MEM/WB.
- wb_ALU_i  in  DATA_W  ALU result from MEM/WB.
- wb_rd_i  in  ADDR_W  destination register from MEM/WB.
- rs_addr_i  in  ADDR_W  ID read port A index.
- rt_addr_i  in  ADDR_W  ID read port B index.
- rs_data_o  out  DATA_W  read port A data, combinational.
- rt_data_o  out  DATA_W  read port B data, combinational.
- wb_data_o  out  DATA_W  selected write-back data, combinational, to forwarding unit.
- wb_we_o  out  1  effective write enable: wb_RegWrite_i && wb_rd_i != 0.
- dbg_addr_i  in  ADDR_W  debug read index.
- dbg_data_o  out  DATA_W  debug read data, array contents only, no bypass.
- wr_cnt_o  out  CNT_W  number of committed writes.

Behaviour:
- Reset (rst=0, asynchronous): all array entries cleared to 0; wr_cnt_o cleared to 0.
  - Combinational outputs follow the cleared state immediately.
  - Release is synchronised by the driving environment; no write occurs on the deassertion edge.
- WB select: wb_data_o = wb_MemtoReg_i ? wb_read_data_i : wb_ALU_i, independent of wb_RegWrite_i.
- Write: on posedge clk with rst=1 and wb_we_o=1, array[wb_rd_i] <= wb_data_o and wr_cnt_o <= wr_cnt_o + 1. Latency is 1 cycle into the array.
- Register 0:
  - Reads as 0 on every port regardless of history.
  - A write to index 0 is dropped, does not bump wr_cnt_o, and is never bypassed.
- Read ports are fully combinational.
  - With BYPASS=1: if wb_we_o and rs_addr_i == wb_rd_i, then rs_data_o = wb_data_o; otherwise rs_data_o = array[rs_addr_i]. rt_data_o follows the same rule.
  - Both ports may bypass in the same cycle (rs == rt == rd).
  - With BYPASS=0: ports read the array only, so the new value is visible the cycle after the write.
- wb_RegWrite_i=0: no array change and no counter change, even if MemtoReg or data toggle.
- Counter: wraps modulo 2**CNT_W silently, with no saturation and no flag.
- No stall or flush inputs: MEM/WB bubbles arrive with RegWrite=0 and are naturally ignored.
- X-safety: a write with RegWrite=1 and X on data is a bench error. The RTL needs no special handling.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W and ADDR_W defaults.
  - REG_ZERO constant (0).
  - MEMTOREG_ALU/MEMTOREG_MEM encodings (0/1), reused by control decode and MEM_WB.
- One sub-module, wb_select: the 2:1 MemtoReg mux producing wb_data_o. It is reused by the forwarding unit's WB-source path.
- Array, bypass, counter and debug port stay in wb_regfile.

Test Plan:
- Reset: drive rst=0 mid-run after writing r5=0x1234. Require rs_data_o for r5 = 0 immediately (before the next clock) and wr_cnt_o = 0. After release, r5 still reads 0.
- Write/read, ALU path: RegWrite=1, MemtoReg=0, ALU=0xDEADBEEF, rd=7. Next cycle, with RegWrite=0, rs=7 gives 0xDEADBEEF; dbg_addr=7 matches; wr_cnt_o = 1.
- Load path and bypass: RegWrite=1, MemtoReg=1, read_data=0xCAFEF00D, ALU=0x11111111, rd=9, rs=rt=9 in the same cycle. Require rs_data_o = rt_data_o = 0xCAFEF00D and dbg_data_o (addr 9) = old value that cycle, then 0xCAFEF00D next cycle.
- r0 immunity: RegWrite=1, rd=0, ALU=0xFFFFFFFF, rs=0. Require rs_data_o = 0 and wb_we_o = 0 that cycle and the next; wr_cnt_o unchanged.
- Disabled write: RegWrite=0, rd=3, ALU=0x55. Require r3 unchanged, no bypass on rs=3, wr_cnt_o unchanged.
- Counter wrap (CNT_W=4): 17 valid writes to rd=1..17 mod 31 (non-zero). Require wr_cnt_o = 1 after the 17th, and every written register holds its last value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, the hard-wired zero
// register index and the MemtoReg source encodings used by decode, MEM/WB
// and write-back.
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 5;

    // Architectural zero register index
    localparam int REG_ZERO = 0;

    // MemtoReg encodings: which MEM/WB field feeds the register file
    localparam logic MEMTOREG_ALU = 1'b0;
    localparam logic MEMTOREG_MEM = 1'b1;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB consumer bundle: write-back request, ID read ports, forwarding
// result, debug read and committed-write counter.
// The master modport is the pipeline side, the slave modport is the register file.
interface wb_regfile_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int CNT_W  = 32
);

    logic              wb_RegWrite_i;
    logic              wb_MemtoReg_i;
    logic [DATA_W-1:0] wb_read_data_i;
    logic [DATA_W-1:0] wb_ALU_i;
    logic [ADDR_W-1:0] wb_rd_i;
    logic [ADDR_W-1:0] rs_addr_i;
    logic [ADDR_W-1:0] rt_addr_i;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic [DATA_W-1:0] wb_data_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_data_o;
    logic [CNT_W-1:0]  wr_cnt_o;

    modport master (
        output wb_RegWrite_i, wb_MemtoReg_i, wb_read_data_i, wb_ALU_i, wb_rd_i,
        output rs_addr_i, rt_addr_i, dbg_addr_i,
        input  rs_data_o, rt_data_o, wb_data_o, wb_we_o, dbg_data_o, wr_cnt_o
    );

    modport slave (
        input  wb_RegWrite_i, wb_MemtoReg_i, wb_read_data_i, wb_ALU_i, wb_rd_i,
        input  rs_addr_i, rt_addr_i, dbg_addr_i,
        output rs_data_o, rt_data_o, wb_data_o, wb_we_o, dbg_data_o, wr_cnt_o
    );

endinterface

// File: rtl/wb_select.sv
// Write-back source mux: picks load data or the ALU result according to
// MemtoReg. Shared with the forwarding unit's WB-source path so both
// always agree on what the WB stage is about to commit.
module wb_select
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              memtoreg,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu,
    output logic [DATA_W-1:0] data
);

    // Select the write-back value; deliberately independent of RegWrite
    always_comb begin
        data = (memtoreg == MEMTOREG_MEM) ? read_data : alu;
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage merged with the 32-entry GPR file. Commits the selected
// WB value one cycle after it is presented, serves two combinational read
// ports with optional write-first bypass, and counts committed writes.
// Entry 0 is never written (the effective write enable excludes it), so it
// holds its reset value of zero forever and needs no read-side masking.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int CNT_W  = 32,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    wb_regfile_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr_reg [DEPTH];
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    logic              rs_hit;
    logic              rt_hit;

    wb_select #(
        .DATA_W (DATA_W)
    ) u_wb_select (
        .memtoreg  (bus.wb_MemtoReg_i),
        .read_data (bus.wb_read_data_i),
        .alu       (bus.wb_ALU_i),
        .data      (wb_data)
    );

    // Effective write enable: writes aimed at the zero register are dropped
    always_comb begin
        wb_we = bus.wb_RegWrite_i && (bus.wb_rd_i != ADDR_W'(REG_ZERO));
    end

    // Register array: asynchronous clear, one-cycle commit of the WB value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                gpr_reg[i] <= '0;
            end
        end else if (wb_we) begin
            gpr_reg[bus.wb_rd_i] <= wb_data;
        end
    end

    // Committed-write counter, wraps silently
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (wb_we) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Bypass hit detection; wb_we already excludes the zero register
    always_comb begin
        rs_hit = (BYPASS != 0) && wb_we && (bus.rs_addr_i == bus.wb_rd_i);
        rt_hit = (BYPASS != 0) && wb_we && (bus.rt_addr_i == bus.wb_rd_i);
    end

    // Read ports: write-first forward on a hit, otherwise array contents
    always_comb begin
        bus.rs_data_o = rs_hit ? wb_data : gpr_reg[bus.rs_addr_i];
        bus.rt_data_o = rt_hit ? wb_data : gpr_reg[bus.rt_addr_i];
    end

    // Forwarding, debug and counter outputs
    always_comb begin
        bus.wb_data_o  = wb_data;
        bus.wb_we_o    = wb_we;
        bus.dbg_data_o = gpr_reg[bus.dbg_addr_i];
        bus.wr_cnt_o   = cnt_reg;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed MEM/WB transactions, a register-file model
// checked every cycle, plus literal expectations for each scenario.
module tb_wb_regfile;
    import cpu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    wb_regfile #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .CNT_W  (CW),
        .BYPASS (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: register contents and write count as the programmer sees them
    logic [DW-1:0] model_mem [32];
    int            model_cnt;
    bit            chk_en = 1'b0;

    logic [DW-1:0] m_sel;
    logic          m_we;
    logic [DW-1:0] m_rs;
    logic [DW-1:0] m_rt;

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model update: a write lands if RegWrite is set and the target is not r0
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) model_mem[i] <= '0;
            model_cnt <= 0;
        end else if (bus.wb_RegWrite_i && bus.wb_rd_i != 0) begin
            model_mem[bus.wb_rd_i] <= bus.wb_MemtoReg_i ? bus.wb_read_data_i : bus.wb_ALU_i;
            model_cnt <= (model_cnt + 1) % (1 << CW);
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            m_sel = bus.wb_MemtoReg_i ? bus.wb_read_data_i : bus.wb_ALU_i;
            m_we  = bus.wb_RegWrite_i && (bus.wb_rd_i != 0);
            m_rs  = (m_we && bus.rs_addr_i == bus.wb_rd_i) ? m_sel : model_mem[bus.rs_addr_i];
            m_rt  = (m_we && bus.rt_addr_i == bus.wb_rd_i) ? m_sel : model_mem[bus.rt_addr_i];
            check("cyc_wb_data", bus.wb_data_o, m_sel);
            check("cyc_wb_we", DW'(bus.wb_we_o), DW'(m_we));
            check("cyc_rs", bus.rs_data_o, m_rs);
            check("cyc_rt", bus.rt_data_o, m_rt);
            check("cyc_dbg", bus.dbg_data_o, model_mem[bus.dbg_addr_i]);
            check("cyc_cnt", DW'(bus.wr_cnt_o), DW'(model_cnt));
        end
    end

    task automatic drive(input bit we, input bit ms, input logic [DW-1:0] rdat,
                         input logic [DW-1:0] alu, input int rd, input int rs,
                         input int rt, input int dbg);
        bus.wb_RegWrite_i  = we;
        bus.wb_MemtoReg_i  = ms;
        bus.wb_read_data_i = rdat;
        bus.wb_ALU_i       = alu;
        bus.wb_rd_i        = AW'(rd);
        bus.rs_addr_i      = AW'(rs);
        bus.rt_addr_i      = AW'(rt);
        bus.dbg_addr_i     = AW'(dbg);
    endtask

    // Advance to just after the next rising edge, where inputs change
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle asynchronous reset pulse, released just after a rising edge
    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_rs_now", bus.rs_data_o, 32'h0);
        check("rst_cnt_now", DW'(bus.wr_cnt_o), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] v;
        int rd;

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("init_r5", bus.rs_data_o, 32'h0);
        check("init_cnt", DW'(bus.wr_cnt_o), 32'h0);
        $display("txn reset: initial state");

        // r5 = 0x1234, then asynchronous reset mid-run
        next_cycle();
        drive(1, 0, 32'h0, 32'h1234, 5, 5, 0, 5);
        @(negedge clk);
        check("r5_bypass", bus.rs_data_o, 32'h1234);
        next_cycle();
        drive(0, 0, 32'h0, 32'h0, 0, 5, 0, 5);
        @(negedge clk);
        check("r5_written", bus.rs_data_o, 32'h1234);
        check("r5_cnt", DW'(bus.wr_cnt_o), 32'h1);
        reset_pulse();
        @(negedge clk);
        check("r5_after_rst", bus.rs_data_o, 32'h0);
        check("r5_dbg_after_rst", bus.dbg_data_o, 32'h0);
        $display("txn reset: r5 cleared by mid-run reset");

        // ALU path write to r7
        next_cycle();
        drive(1, MEMTOREG_ALU, 32'h0, 32'hDEADBEEF, 7, 0, 0, 7);
        @(negedge clk);
        check("r7_dbg_old", bus.dbg_data_o, 32'h0);
        next_cycle();
        drive(0, 0, 32'h0, 32'h0, 0, 7, 7, 7);
        @(negedge clk);
        check("r7_rs", bus.rs_data_o, 32'hDEADBEEF);
        check("r7_dbg", bus.dbg_data_o, 32'hDEADBEEF);
        check("r7_cnt", DW'(bus.wr_cnt_o), 32'h1);
        $display("txn alu write: r7 <= deadbeef");

        // Load path with both ports bypassing
        next_cycle();
        drive(1, MEMTOREG_MEM, 32'hCAFEF00D, 32'h11111111, 9, 9, 9, 9);
        @(negedge clk);
        check("r9_rs_bypass", bus.rs_data_o, 32'hCAFEF00D);
        check("r9_rt_bypass", bus.rt_data_o, 32'hCAFEF00D);
        check("r9_dbg_old", bus.dbg_data_o, 32'h0);
        check("r9_wb_data", bus.wb_data_o, 32'hCAFEF00D);
        next_cycle();
        drive(0, MEMTOREG_MEM, 32'hCAFEF00D, 32'h11111111, 9, 9, 9, 9);
        @(negedge clk);
        check("r9_dbg_new", bus.dbg_data_o, 32'hCAFEF00D);
        check("r9_rs_nobyp", bus.rs_data_o, 32'hCAFEF00D);
        check("r9_cnt", DW'(bus.wr_cnt_o), 32'h2);
        $display("txn load write: r9 <= cafef00d with dual bypass");

        // Write to r0 is dropped
        next_cycle();
        drive(1, MEMTOREG_ALU, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0);
        @(negedge clk);
        check("r0_rs", bus.rs_data_o, 32'h0);
        check("r0_we", DW'(bus.wb_we_o), 32'h0);
        check("r0_wb_data", bus.wb_data_o, 32'hFFFFFFFF);
        next_cycle();
        @(negedge clk);
        check("r0_rs_next", bus.rs_data_o, 32'h0);
        check("r0_we_next", DW'(bus.wb_we_o), 32'h0);
        check("r0_cnt", DW'(bus.wr_cnt_o), 32'h2);
        $display("txn r0 write: dropped");

        // RegWrite=0 with live data: nothing changes, no bypass
        next_cycle();
        drive(0, MEMTOREG_ALU, 32'h0, 32'h55, 3, 3, 9, 3);
        @(negedge clk);
        check("r3_rs_nobyp", bus.rs_data_o, 32'h0);
        check("r3_rt_r9", bus.rt_data_o, 32'hCAFEF00D);
        next_cycle();
        drive(0, MEMTOREG_MEM, 32'h66, 32'h55, 3, 3, 9, 3);
        @(negedge clk);
        check("r3_dbg", bus.dbg_data_o, 32'h0);
        check("r3_cnt", DW'(bus.wr_cnt_o), 32'h2);
        $display("txn disabled write: r3 untouched");

        // Counter wrap: fresh reset, then 17 writes with a 4-bit counter
        reset_pulse();
        for (int i = 0; i < 17; i++) begin
            rd = (i % 31) + 1;
            v  = 32'hA5000000 + DW'(i * 32'h101);
            if (i % 2 == 0) drive(1, MEMTOREG_ALU, ~v, v, rd, rd, 0, rd);
            else            drive(1, MEMTOREG_MEM, v, ~v, rd, rd, 0, rd);
            @(negedge clk);
            check("wrap_bypass", bus.rs_data_o, v);
            next_cycle();
        end
        drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        check("wrap_cnt", DW'(bus.wr_cnt_o), 32'h1);
        $display("txn counter wrap: 17 writes, count 1");
        for (int i = 0; i < 17; i++) begin
            next_cycle();
            drive(0, 0, 32'h0, 32'h0, 0, 0, 0, i + 1);
            @(negedge clk);
            check("wrap_hold", bus.dbg_data_o, 32'hA5000000 + DW'(i * 32'h101));
        end
        $display("txn counter wrap: contents of r1..r17 verified");

        next_cycle();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
